// File: rtl/adpll_hop_seq.sv
// Channel-hop sequencer: reprograms the ADPLL over its register port, then polls
// for lock, saturation or timeout and parks the ADPLL disabled on any failure.
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h00
`endif
`ifndef FCW
`define FCW 'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h08
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h0C
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 'h10
`endif

module adpll_hop_seq #(
  parameter int ADDR_W       = `ADPLL_ADDR_W,
  parameter int FCWW         = `FCWW,
  parameter int POLL_GAP     = 16,
  parameter int LOCK_TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FCWW-1:0]   fcw_in,
  input  logic [1:0]        mode_in,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              err_timeout,
  output logic              err_sat,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       wdata,
  output logic              wstrb,
  input  logic [31:0]       rdata,
  input  logic              ready
);

  typedef enum logic [3:0] {
    IDLE, WR_DIS, WR_FCW, WR_MODE, WR_EN, GAP, RD_LOCK, RD_SAT, WR_OFF, FIN
  } state_t;

  localparam logic [15:0] TMAX    = 16'(LOCK_TIMEOUT);
  localparam logic [7:0]  GAP_END = 8'(POLL_GAP - 1);

  state_t            state_q, state_d;
  logic              gap_q, gap_d;
  logic              rbit_q, rbit_d;
  logic [FCWW-1:0]   fcw_q, fcw_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic              abort_q, abort_d;
  logic              locked_q, locked_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_sat_q, err_sat_d;
  logic              in_txn;
  logic              unused_rdata;

  assign unused_rdata = ^rdata[31:1];
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign locked       = locked_q;
  assign err_timeout  = err_timeout_q;
  assign err_sat      = err_sat_q;

  // The gap cycle after a handshake stays in the transaction state with valid low.
  always_comb begin
    in_txn  = 1'b1;
    address = '0;
    wdata   = '0;
    wstrb   = 1'b0;
    case (state_q)
      WR_DIS:  begin address = ADDR_W'(`ADPLL_EN);   wstrb = 1'b1; end
      WR_FCW:  begin address = ADDR_W'(`FCW);        wstrb = 1'b1; wdata = 32'(fcw_q); end
      WR_MODE: begin address = ADDR_W'(`ADPLL_MODE); wstrb = 1'b1; wdata = {30'd0, mode_q}; end
      WR_EN:   begin address = ADDR_W'(`ADPLL_EN);   wstrb = 1'b1; wdata = 32'd1; end
      WR_OFF:  begin address = ADDR_W'(`ADPLL_EN);   wstrb = 1'b1; end
      RD_LOCK: address = ADDR_W'(`ADPLL_LOCK);
      RD_SAT:  address = ADDR_W'(`ADPLL_SAT);
      default: in_txn = 1'b0;
    endcase
    valid = in_txn && !gap_q;
  end

  always_comb begin
    state_d       = state_q;
    gap_d         = 1'b0;
    rbit_d        = rbit_q;
    fcw_d         = fcw_q;
    mode_d        = mode_q;
    tcnt_d        = tcnt_q;
    pcnt_d        = pcnt_q;
    abort_d       = abort_q | (abort & busy);
    locked_d      = locked_q;
    err_timeout_d = err_timeout_q;
    err_sat_d     = err_sat_q;

    if ((state_q inside {WR_EN, GAP, RD_LOCK, RD_SAT, WR_OFF}) && (tcnt_q != TMAX))
      tcnt_d = tcnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          fcw_d         = fcw_in;
          mode_d        = mode_in;
          locked_d      = 1'b0;
          err_timeout_d = 1'b0;
          err_sat_d     = 1'b0;
          tcnt_d        = '0;
          state_d       = WR_DIS;
        end
      end
      GAP: begin
        if (abort_d) begin
          state_d = WR_OFF;
        end else if (pcnt_q == GAP_END) begin
          if (tcnt_q == TMAX) begin
            err_timeout_d = 1'b1;
            state_d       = WR_OFF;
          end else begin
            state_d = RD_LOCK;
          end
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      FIN: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        if (!gap_q) begin
          if (valid && ready) begin
            gap_d  = 1'b1;
            rbit_d = rdata[0];
          end
        end else begin
          case (state_q)
            WR_DIS:  state_d = WR_FCW;
            WR_FCW:  state_d = WR_MODE;
            WR_MODE: begin state_d = WR_EN; tcnt_d = '0; end
            WR_EN:   state_d = RD_LOCK;
            RD_LOCK: begin
              if (rbit_q) begin locked_d = 1'b1; state_d = FIN; end
              else state_d = RD_SAT;
            end
            RD_SAT: begin
              if (rbit_q) begin err_sat_d = 1'b1; state_d = WR_OFF; end
              else begin pcnt_d = '0; state_d = GAP; end
            end
            WR_OFF:  state_d = FIN;
            default: state_d = IDLE;
          endcase
          // A pending abort overrides any result once the current transaction ends.
          if (abort_d && (state_q != WR_OFF)) begin
            state_d       = WR_OFF;
            locked_d      = 1'b0;
            err_timeout_d = 1'b0;
            err_sat_d     = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gap_q         <= 1'b0;
      rbit_q        <= 1'b0;
      fcw_q         <= '0;
      mode_q        <= '0;
      tcnt_q        <= '0;
      pcnt_q        <= '0;
      abort_q       <= 1'b0;
      locked_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_sat_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      rbit_q        <= rbit_d;
      fcw_q         <= fcw_d;
      mode_q        <= mode_d;
      tcnt_q        <= tcnt_d;
      pcnt_q        <= pcnt_d;
      abort_q       <= abort_d;
      locked_q      <= locked_d;
      err_timeout_q <= err_timeout_d;
      err_sat_q     <= err_sat_d;
    end
  end

endmodule

// File: tb/tb_adpll_hop_seq.sv
// Directed bench for adpll_hop_seq with a register-slave model whose lock/sat
// answers and ready latency are steered per scenario.
module tb_adpll_hop_seq;

  localparam logic [7:0] A_EN   = 8'h00;
  localparam logic [7:0] A_FCW  = 8'h04;
  localparam logic [7:0] A_MODE = 8'h08;
  localparam logic [7:0] A_LOCK = 8'h0C;
  localparam logic [7:0] A_SAT  = 8'h10;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [25:0] fcw;
  logic [1:0]  mode;
  logic        busy, done, locked, err_timeout, err_sat;
  logic        valid, wstrb;
  logic [7:0]  address;
  logic [31:0] wdata, rdata;
  logic        ready = 1'b0;

  int total = 0;
  int bad   = 0;

  int slvDelay = 0;
  int waitCnt  = 0;
  int lockHit  = 0;
  int pollBase = 0;
  logic satVal = 1'b0;
  logic lockVal;
  int wrN    = 0;
  int lockRd = 0;
  int satRd  = 0;
  logic [7:0]  wrAddr [0:63];
  logic [31:0] wrData [0:63];

  adpll_hop_seq #(
    .ADDR_W(8), .FCWW(26), .POLL_GAP(16), .LOCK_TIMEOUT(200)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fcw_in(fcw), .mode_in(mode),
    .busy(busy), .done(done), .locked(locked),
    .err_timeout(err_timeout), .err_sat(err_sat),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  assign lockVal = (lockHit != 0) && ((lockRd - pollBase + 1) >= lockHit);
  assign rdata = (address == A_LOCK) ? {31'd0, lockVal} :
                 (address == A_SAT)  ? {31'd0, satVal}  : 32'hDEAD_BEE0;

  // Registered-ready slave: raises ready slvDelay+1 cycles after valid and logs traffic.
  always @(posedge clk) begin
    if (valid && ready) begin
      ready   <= 1'b0;
      waitCnt <= 0;
      if (wstrb) begin
        if (wrN < 64) begin
          wrAddr[wrN] <= address;
          wrData[wrN] <= wdata;
        end
        wrN <= wrN + 1;
      end else if (address == A_LOCK) lockRd <= lockRd + 1;
      else if (address == A_SAT) satRd <= satRd + 1;
    end else if (ready) ready <= 1'b0;
    else if (valid) begin
      if (waitCnt >= slvDelay) ready <= 1'b1;
      else waitCnt <= waitCnt + 1;
    end else waitCnt <= 0;
  end

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fcw = '0; mode = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({valid, busy, done, locked, err_timeout, err_sat, wstrb} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=0000000", {valid, busy, done, locked, err_timeout, err_sat, wstrb});
    end
    total++;
    if ({address, wdata} !== 40'd0) begin
      bad++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h want 0", address, wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_seq_lock;
    int base, satBase, n;
    logic expV;
    logic [7:0]  ea [4];
    logic [31:0] ed [4];
    ea[0] = A_EN; ea[1] = A_FCW;         ea[2] = A_MODE; ea[3] = A_EN;
    ed[0] = 0;    ed[1] = 32'h0262_0000; ed[2] = 1;      ed[3] = 1;
    base = wrN; pollBase = lockRd; satBase = satRd; lockHit = 3; satVal = 1'b0;
    fcw = 26'h2620000; mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      expV = (k == 12) ? 1'b1 : ((k % 3) != 2);
      total++;
      if (valid !== expV) begin
        bad++;
        $display("[TB] FAIL seq_valid_c%0d got=%b want=%b", k, valid, expV);
      end
      if (k < 12) @(negedge clk);
    end
    total++;
    if (address !== A_LOCK || wstrb !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_poll got addr=%h wstrb=%b want addr=%h wstrb=0", address, wstrb, A_LOCK);
    end
    n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lock_done got done=%b busy=%b want 1 1", done, busy);
    end
    total++;
    if ({locked, err_timeout, err_sat} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL lock_flags got=%b want=100", {locked, err_timeout, err_sat});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || locked !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lock_after got done=%b busy=%b locked=%b want 0 0 1", done, busy, locked);
    end
    total++;
    if ((wrN - base) !== 4 || (lockRd - pollBase) !== 3 || (satRd - satBase) !== 2) begin
      bad++;
      $display("[TB] FAIL lock_counts got wr=%0d lock=%0d sat=%0d want 4 3 2", wrN - base, lockRd - pollBase, satRd - satBase);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wrAddr[base + i] !== ea[i] || wrData[base + i] !== ed[i]) begin
        bad++;
        $display("[TB] FAIL write%0d got %h=%h want %h=%h", i, wrAddr[base + i], wrData[base + i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int base, n;
    base = wrN; pollBase = lockRd; lockHit = 0; satVal = 1'b0;
    fcw = 26'h1234567; mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1 || {locked, err_timeout, err_sat} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL timeout_flags got done=%b flags=%b want 1 010", done, {locked, err_timeout, err_sat});
    end
    total++;
    if ((wrN - base) !== 5 || wrAddr[wrN - 1] !== A_EN || wrData[wrN - 1] !== 32'd0) begin
      bad++;
      $display("[TB] FAIL timeout_off got n=%0d last %h=%h want 5 00=0", wrN - base, wrAddr[wrN - 1], wrData[wrN - 1]);
    end
    @(negedge clk);
  endtask

  task automatic test_sat;
    int base, satBase, n;
    base = wrN; pollBase = lockRd; satBase = satRd; lockHit = 0; satVal = 1'b1;
    fcw = 26'h0ABCDEF; mode = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1 || {locked, err_timeout, err_sat} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL sat_flags got done=%b flags=%b want 1 001", done, {locked, err_timeout, err_sat});
    end
    total++;
    if ((wrN - base) !== 5 || wrAddr[wrN - 1] !== A_EN || wrData[wrN - 1] !== 32'd0 ||
        (lockRd - pollBase) !== 1 || (satRd - satBase) !== 1) begin
      bad++;
      $display("[TB] FAIL sat_traffic got wr=%0d last %h=%h lock=%0d sat=%0d want 5 00=0 1 1",
               wrN - base, wrAddr[wrN - 1], wrData[wrN - 1], lockRd - pollBase, satRd - satBase);
    end
    satVal = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int base, n;
    base = wrN; pollBase = lockRd; lockHit = 1; slvDelay = 5;
    fcw = 26'h155AAAA; mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(valid && address == A_FCW) && n < 100) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1 || {locked, err_timeout, err_sat} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL abort_flags got done=%b flags=%b want 1 000", done, {locked, err_timeout, err_sat});
    end
    total++;
    if ((wrN - base) !== 3 || wrData[base + 1] !== 32'h0155_AAAA ||
        wrAddr[base + 2] !== A_EN || wrData[base + 2] !== 32'd0 || (lockRd - pollBase) !== 0) begin
      bad++;
      $display("[TB] FAIL abort_traffic got wr=%0d fcw=%h last %h=%h polls=%0d want 3 0155aaaa 00=0 0",
               wrN - base, wrData[base + 1], wrAddr[base + 2], wrData[base + 2], lockRd - pollBase);
    end
    slvDelay = 0; lockHit = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int base, n, busyCnt;
    base = wrN; pollBase = lockRd; lockHit = 0;
    fcw = 26'h3000001; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(valid && address == A_FCW) && n < 100) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(valid && address == A_LOCK) && n < 100) begin @(negedge clk); n++; end
    total++;
    if ((wrN - base) !== 4 || wrAddr[base] !== A_EN || wrAddr[base + 1] !== A_FCW) begin
      bad++;
      $display("[TB] FAIL busy_start got wr=%0d a0=%h a1=%h want 4 00 04", wrN - base, wrAddr[base], wrAddr[base + 1]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({valid, busy, done, wstrb} !== 4'd0 || address !== 8'd0 || wdata !== 32'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset got v/b/d/s=%b addr=%h data=%h want 0", {valid, busy, done, wstrb}, address, wdata);
    end
    base = wrN; busyCnt = 0;
    repeat (40) begin @(negedge clk); if (busy) busyCnt++; end
    total++;
    if (busyCnt !== 0 || wrN !== base) begin
      bad++;
      $display("[TB] FAIL no_extra_seq got busyCycles=%0d writes=%0d want 0 0", busyCnt, wrN - base);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_over_start got busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_seq_lock();
    test_timeout();
    test_sat();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
